// File: rtl/integral_image_scanout_if.sv
// integral_image_scanout_if
//   Bundles the VGA timing, II RAM read port and display outputs of
//   integral_image_scanout.
//   slave  : the scanout block (consumes timing/RAM data, drives addr/rgb)
//   master : the surrounding system (timing generator, II RAM, VGA stage)
//   Signals: vsync, active_area, mode[1:0], shift[4:0], ii_rddata[II_W]
//            -> slave; rd_addr[ADDR_W], vsync_out, pix_valid, rgb[11:0],
//            overrun -> master.
//   When DETECT_OVERLAY_EN is defined, box_valid/box_x/box_y/box_size are
//   added as master-driven inputs.
interface integral_image_scanout_if #(
  parameter int ADDR_W = 15,
  parameter int II_W   = 20
);
  logic              vsync;
  logic              active_area;
  logic [1:0]        mode;
  logic [4:0]        shift;
  logic [ADDR_W-1:0] rd_addr;
  logic [II_W-1:0]   ii_rddata;
  logic              vsync_out;
  logic              pix_valid;
  logic [11:0]       rgb;
  logic              overrun;
`ifdef DETECT_OVERLAY_EN
  logic              box_valid;
  logic [7:0]        box_x;
  logic [7:0]        box_y;
  logic [7:0]        box_size;
`endif

  modport master (
`ifdef DETECT_OVERLAY_EN
    output box_valid, box_x, box_y, box_size,
`endif
    output vsync, active_area, mode, shift, ii_rddata,
    input  rd_addr, vsync_out, pix_valid, rgb, overrun
  );

  modport slave (
`ifdef DETECT_OVERLAY_EN
    input  box_valid, box_x, box_y, box_size,
`endif
    input  vsync, active_area, mode, shift, ii_rddata,
    output rd_addr, vsync_out, pix_valid, rgb, overrun
  );
endinterface

// File: rtl/integral_image_scanout.sv
// integral_image_scanout
//   Walks the integral-image (II) RAM in raster order under external VGA
//   timing, rebuilds per-pixel intensity from the II stream and emits 12-bit
//   grey RGB.
//   Ports:
//     clk_vga : pixel clock
//     rst_n   : asynchronous active-low reset
//     bus     : integral_image_scanout_if.slave (timing in, RAM read port,
//               mode/shift config, rgb/pix_valid/vsync_out/overrun out)
//   Modes: 0 pixel, 1 II >> shift, 2 |horizontal gradient|, 3 column ramp.
//   Optional: define DETECT_OVERLAY_EN to draw a red box outline whose
//   position/size come in on the bus and are latched at frame start.
module integral_image_scanout #(
  parameter int II_WIDTH   = 160,
  parameter int II_HEIGHT  = 120,
  parameter int II_W       = 20,
  parameter int ADDR_W     = 15,
  parameter int RD_LATENCY = 1,
  parameter int PIX_W      = 8
) (
  input  logic                    clk_vga,
  input  logic                    rst_n,
  integral_image_scanout_if.slave bus
);

  localparam int NPIX  = II_WIDTH * II_HEIGHT;
  localparam int IDX_W = $clog2(II_WIDTH);
  localparam int COL_W = (IDX_W > PIX_W) ? IDX_W : PIX_W;
  localparam int ROW_W = $clog2(II_HEIGHT) + 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(II_WIDTH - 1);
  localparam logic [II_W-1:0]   PIX_MAX   = II_W'((1 << PIX_W) - 1);

  localparam logic [1:0] MODE_PIXEL = 2'd0;
  localparam logic [1:0] MODE_SCALE = 2'd1;
  localparam logic [1:0] MODE_GRAD  = 2'd2;
  localparam logic [1:0] MODE_RAMP  = 2'd3;

  // ---------------------------------------------------------------------
  // Address stage
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0] rd_addr_q;
  logic              at_last;   // the final address has already been read once
  logic              overrun_q;

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr_q <= '0;
      at_last   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (!bus.vsync) begin
      rd_addr_q <= '0;
      at_last   <= 1'b0;
    end else if (bus.active_area) begin
      if (rd_addr_q == LAST_ADDR) begin
        if (at_last) overrun_q <= 1'b1;
        at_last <= 1'b1;
      end else begin
        rd_addr_q <= rd_addr_q + 1'b1;
      end
    end
  end

  assign bus.rd_addr = rd_addr_q;
  assign bus.overrun = overrun_q;

  // ---------------------------------------------------------------------
  // Timing delay to line up with RAM data
  // ---------------------------------------------------------------------
  logic [RD_LATENCY-1:0] vs_dly;
  logic [RD_LATENCY-1:0] act_dly;

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      vs_dly  <= '1;
      act_dly <= '0;
    end else begin
      vs_dly[0]  <= bus.vsync;
      act_dly[0] <= bus.active_area;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vs_dly[i]  <= vs_dly[i-1];
        act_dly[i] <= act_dly[i-1];
      end
    end
  end

  logic d_vsync;
  logic d_active;
  assign d_vsync  = vs_dly[RD_LATENCY-1];
  assign d_active = act_dly[RD_LATENCY-1];

  // ---------------------------------------------------------------------
  // Data stage
  // ---------------------------------------------------------------------
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [IDX_W-1:0] col_idx;
  logic [II_W-1:0]  linebuf [II_WIDTH];
  logic [II_W-1:0]  prev_i;
  logic [II_W-1:0]  prev_up;
  logic [PIX_W-1:0] prev_p;
  logic [1:0]       mode_q;
  logic [4:0]       shift_q;

  logic [II_W-1:0]  ii_cur;
  logic [II_W-1:0]  up;
  logic [II_W-1:0]  left;
  logic [II_W-1:0]  upleft;
  logic [II_W-1:0]  p_raw;
  logic [PIX_W-1:0] p_sat;
  logic [II_W-1:0]  scaled;
  logic [PIX_W-1:0] scaled_sat;
  logic [PIX_W-1:0] p_prev_eff;
  logic [PIX_W-1:0] grad;
  logic [PIX_W-1:0] result;
  logic [3:0]       g;

  assign col_idx = col[IDX_W-1:0];
  assign ii_cur  = bus.ii_rddata;

  // Row 0 masks the line buffer, so nothing left over from an earlier frame
  // (or from before a reset) can leak into the first row.
  assign up     = (row == '0) ? '0 : linebuf[col_idx];
  assign left   = (col == '0) ? '0 : prev_i;
  assign upleft = (col == '0 || row == '0) ? '0 : prev_up;

  // Wraps modulo 2^II_W; the true pixel is always recovered as long as it
  // fits in II_W bits, even when the integral itself has wrapped.
  assign p_raw      = ii_cur - left - up + upleft;
  assign p_sat      = (p_raw > PIX_MAX) ? PIX_MAX[PIX_W-1:0] : p_raw[PIX_W-1:0];
  assign scaled     = ii_cur >> shift_q;
  assign scaled_sat = (scaled > PIX_MAX) ? PIX_MAX[PIX_W-1:0] : scaled[PIX_W-1:0];
  assign p_prev_eff = (col == '0) ? '0 : prev_p;
  assign grad       = (p_sat >= p_prev_eff) ? (p_sat - p_prev_eff) : (p_prev_eff - p_sat);

  always_comb begin
    result = p_sat;
    case (mode_q)
      MODE_PIXEL: result = p_sat;
      MODE_SCALE: result = scaled_sat;
      MODE_GRAD:  result = grad;
      MODE_RAMP:  result = col[PIX_W-1:0];
      default:    result = p_sat;
    endcase
  end

  assign g = result[PIX_W-1 -: 4];

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      col     <= '0;
      row     <= '0;
      prev_i  <= '0;
      prev_up <= '0;
      prev_p  <= '0;
      mode_q  <= MODE_PIXEL;
      shift_q <= '0;
    end else if (!d_vsync) begin
      col     <= '0;
      row     <= '0;
      mode_q  <= bus.mode;
      shift_q <= bus.shift;
    end else if (d_active) begin
      prev_i  <= ii_cur;
      prev_up <= up;
      prev_p  <= p_sat;
      if (col == COL_LAST) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Line buffer is plain RAM: no reset, one read (above) and one write per
  // active pixel at the same column.
  always_ff @(posedge clk_vga) begin
    if (d_vsync && d_active) linebuf[col_idx] <= ii_cur;
  end

`ifdef DETECT_OVERLAY_EN
  logic       box_valid_q;
  logic [7:0] box_x_q;
  logic [7:0] box_y_q;
  logic [7:0] box_size_q;
  logic       border;

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      box_valid_q <= 1'b0;
      box_x_q     <= '0;
      box_y_q     <= '0;
      box_size_q  <= '0;
    end else if (!d_vsync) begin
      box_valid_q <= bus.box_valid;
      box_x_q     <= bus.box_x;
      box_y_q     <= bus.box_y;
      box_size_q  <= bus.box_size;
    end
  end

  // Clipping is implicit: col/row never leave the frame, so edges that fall
  // outside it simply never match.
  always_comb begin
    logic [15:0] cx;
    logic [15:0] ry;
    logic [15:0] x0;
    logic [15:0] x1;
    logic [15:0] y0;
    logic [15:0] y1;
    cx = 16'(col);
    ry = 16'(row);
    x0 = 16'(box_x_q);
    y0 = 16'(box_y_q);
    x1 = 16'(box_x_q) + 16'(box_size_q);
    y1 = 16'(box_y_q) + 16'(box_size_q);
    border = box_valid_q &&
             ((((cx == x0) || (cx == x1)) && (ry >= y0) && (ry <= y1)) ||
              (((ry == y0) || (ry == y1)) && (cx >= x0) && (cx <= x1)));
  end
`endif

  // ---------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------
  logic [11:0] rgb_q;
  logic        pix_valid_q;
  logic        vsync_out_q;

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q       <= '0;
      pix_valid_q <= 1'b0;
      vsync_out_q <= 1'b1;
    end else begin
      pix_valid_q <= d_active;
      vsync_out_q <= d_vsync;
      if (!d_active) begin
        rgb_q <= '0;
`ifdef DETECT_OVERLAY_EN
      end else if (border) begin
        rgb_q <= 12'hF00;
`endif
      end else begin
        rgb_q <= {g, g, g};
      end
    end
  end

  assign bus.rgb       = rgb_q;
  assign bus.pix_valid = pix_valid_q;
  assign bus.vsync_out = vsync_out_q;

endmodule

// File: tb/tb_integral_image_scanout.sv
module tb_integral_image_scanout;

  localparam int W    = 160;
  localparam int H    = 120;
  localparam int NPIX = W * H;
  localparam int AW   = 15;
  localparam int IW   = 24;
  localparam int LAT  = 3;
  localparam int PW   = 8;
  localparam int CAPN = 19300;

  logic clk_vga = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_vga = ~clk_vga;

  integral_image_scanout_if #(.ADDR_W(AW), .II_W(IW)) bus ();

  integral_image_scanout #(
    .II_WIDTH(W), .II_HEIGHT(H), .II_W(IW), .ADDR_W(AW),
    .RD_LATENCY(LAT), .PIX_W(PW)
  ) dut (
    .clk_vga(clk_vga),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk_vga) cyc <= cyc + 1;

  // II RAM model with RD_LATENCY-deep read pipeline
  logic [IW-1:0] ram  [NPIX];
  logic [IW-1:0] pipe [LAT];

  always @(posedge clk_vga) begin
    pipe[0] <= ram[int'(bus.rd_addr)];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.ii_rddata = pipe[LAT-1];

  // Output capture, restarted by the delayed vsync
  logic [11:0] cap_rgb [CAPN];
  int          cap_cyc [CAPN];
  int          cap_n = 0;

  always @(negedge clk_vga) begin
    if (!bus.vsync_out) begin
      cap_n = 0;
    end else if (bus.pix_valid) begin
      if (cap_n < CAPN) begin
        cap_rgb[cap_n] = bus.rgb;
        cap_cyc[cap_n] = cyc;
      end
      cap_n++;
    end
  end

  int mark    = -1;
  int act_cyc = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int img(input int kind, input int x, input int y);
    case (kind)
      0:       return 1;
      1:       return 255;
      2:       return (x == 5 && y == 3) ? 200 : 0;
      default: return (x * 37 + y * 101 + 13) % 256;
    endcase
  endfunction

  task automatic load_image(input int kind);
    logic [IW-1:0] l, u, ul;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        l  = (x > 0) ? ram[y*W + x - 1] : '0;
        u  = (y > 0) ? ram[(y-1)*W + x] : '0;
        ul = (x > 0 && y > 0) ? ram[(y-1)*W + x - 1] : '0;
        ram[y*W + x] = IW'(img(kind, x, y)) + l + u - ul;
      end
    end
  endtask

  function automatic int exp_rgb(input int kind, input int mode, input int x, input int y);
    int v, pv, r, gg;
    v  = img(kind, x, y);
    pv = (x == 0) ? 0 : img(kind, x - 1, y);
    case (mode)
      0:       r = (v > 255) ? 255 : v;
      2:       r = (v >= pv) ? v - pv : pv - v;
      default: r = x & 255;
    endcase
    gg = (r >> 4) & 15;
    return (gg << 8) | (gg << 4) | gg;
  endfunction

  task automatic check_frame(input string tag, input int kind, input int mode, input int npix);
    int bad;
    bad = 0;
    for (int i = 0; i < npix; i++)
      if (int'(cap_rgb[i]) !== exp_rgb(kind, mode, i % W, i / W)) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic frame_start();
    @(negedge clk_vga);
    bus.active_area = 1'b0;
    bus.vsync       = 1'b0;
    repeat (4) @(negedge clk_vga);
    bus.vsync = 1'b1;
    repeat (2) @(negedge clk_vga);
  endtask

  task automatic drive(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_vga);
      bus.active_area = 1'b1;
      if (i == mark) act_cyc = cyc;
    end
  endtask

  task automatic flush();
    @(negedge clk_vga);
    bus.active_area = 1'b0;
    repeat (LAT + 4) @(negedge clk_vga);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rd_addr"}, int'(bus.rd_addr), 0);
    chk({tag, "_rgb"}, int'(bus.rgb), 0);
    chk({tag, "_pix_valid"}, int'(bus.pix_valid), 0);
    chk({tag, "_vsync_out"}, int'(bus.vsync_out), 1);
    chk({tag, "_overrun"}, int'(bus.overrun), 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bus.vsync       = 1'b1;
    bus.active_area = 1'b0;
    bus.mode        = 2'd0;
    bus.shift       = 5'd0;

    repeat (3) @(negedge clk_vga);
    check_reset_values("reset");
    rst_n = 1'b1;

    // all-ones image: p=1 everywhere -> black
    load_image(0);
    frame_start();
    drive(3 * W);
    flush();
    chk("ones_count", cap_n, 3 * W);
    check_frame("ones_pixels", 0, 0, 3 * W);

    // single bright pixel at (5,3)
    load_image(2);
    mark = 3 * W + 5;
    frame_start();
    drive(5 * W);
    flush();
    mark = -1;
    chk("single_count", cap_n, 5 * W);
    check_frame("single_pixels", 2, 0, 5 * W);
    n = 0;
    for (int i = 0; i < 5 * W; i++) if (cap_rgb[i] == 12'hCCC) n++;
    chk("single_ccc_hits", n, 1);
    chk("single_latency", cap_cyc[3*W + 5] - act_cyc, LAT + 1);

    // gradient mode on the same image: edges at (5,3) and (6,3)
    bus.mode = 2'd2;
    frame_start();
    drive(5 * W);
    flush();
    check_frame("grad_pixels", 2, 2, 5 * W);
    chk("grad_right_edge", int'(cap_rgb[3*W + 6]), 'hCCC);

    // varied image, checks reconstruction across row/column wraps
    bus.mode = 2'd0;
    load_image(3);
    frame_start();
    drive(4 * W);
    flush();
    chk("golden_count", cap_n, 4 * W);
    check_frame("golden_pixels", 3, 0, 4 * W);

    // all-255 full frame plus one extra active pixel
    load_image(1);
    frame_start();
    drive(NPIX + 1);
    flush();
    chk("full_count", cap_n, NPIX + 1);
    check_frame("full_white", 1, 0, NPIX);
    chk("ovr_rd_addr_hold", int'(bus.rd_addr), NPIX - 1);
    chk("ovr_set", int'(bus.overrun), 1);
    frame_start();
    chk("ovr_rd_addr_vsync", int'(bus.rd_addr), 0);
    chk("ovr_sticky", int'(bus.overrun), 1);

    // mode 1, shift 12; mode change to 3 mid-frame must be ignored
    bus.mode  = 2'd1;
    bus.shift = 5'd12;
    frame_start();
    drive(2 * W);
    bus.mode = 2'd3;
    drive(NPIX - 2 * W);
    flush();
    chk("scale_row0_end", int'(cap_rgb[W - 1]), 'h000);
    chk("scale_last", int'(cap_rgb[NPIX - 1]), 'hFFF);

    // the new mode takes effect at the next frame
    frame_start();
    drive(W);
    flush();
    check_frame("ramp_row", 1, 3, W);
    chk("ramp_col159", int'(cap_rgb[W - 1]), 'h999);

    // reset in the middle of row 60
    bus.mode  = 2'd0;
    bus.shift = 5'd0;
    frame_start();
    drive(60 * W + 80);
    chk("pre_reset_overrun", int'(bus.overrun), 1);
    @(negedge clk_vga);
    bus.active_area = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    repeat (3) @(negedge clk_vga);
    rst_n = 1'b1;
    load_image(3);
    frame_start();
    drive(4 * W);
    flush();
    chk("post_reset_count", cap_n, 4 * W);
    check_frame("post_reset_golden", 3, 0, 4 * W);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
